// File: rtl/fault_fsm_moore.sv
// rtl/fault_fsm_moore.sv - 4-cell battery-pack protection FSM (NORMAL/WARNING/FAULT/SHUTDOWN)
module fault_fsm_moore #(
  parameter int unsigned OV_MV           = 4200,
  parameter int unsigned UV_MV           = 2800,
  parameter int unsigned OT_C            = 60,
  parameter int unsigned OC_MA           = 1000,
  parameter int unsigned IMB_MV          = 150,
  parameter int unsigned PERSIST_CYCLES  = 4,
  parameter int unsigned SHUTDOWN_CYCLES = 4,
  parameter int unsigned CLEAR_CYCLES    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cell_voltage [4],
  input  logic [15:0] current,
  input  logic [7:0]  temp_flag [4],
  input  logic [3:0]  mask,
  output logic [1:0]  state,
  output logic        shutdown_signal
);

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'b00,
    ST_WARNING  = 2'b01,
    ST_FAULT    = 2'b10,
    ST_SHUTDOWN = 2'b11
  } state_e;

  localparam logic [15:0] OV_L    = 16'(OV_MV);
  localparam logic [15:0] UV_L    = 16'(UV_MV);
  localparam logic [7:0]  OT_L    = 8'(OT_C);
  localparam logic [15:0] OC_L    = 16'(OC_MA);
  localparam logic [15:0] IMB_L   = 16'(IMB_MV);
  localparam logic [7:0]  PERS_L  = 8'(PERSIST_CYCLES);
  localparam logic [7:0]  SHDN_L  = 8'(PERSIST_CYCLES + SHUTDOWN_CYCLES);
  localparam logic [7:0]  CLEAR_L = 8'(CLEAR_CYCLES);

  state_e      state_q, state_d;
  logic [7:0]  flt_run_q, flt_run_d;
  logic [7:0]  clr_run_q, clr_run_d;

  logic        cell_fault;
  logic        imb_fault;
  logic        fault_now;
  logic [2:0]  n_unmasked;
  logic [15:0] v_max, v_min;

  // Min/max only track unmasked cells; imbalance needs at least two of them.
  always_comb begin
    cell_fault = 1'b0;
    n_unmasked = 3'd0;
    v_max      = 16'h0000;
    v_min      = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      if (!mask[i]) begin
        if (cell_voltage[i] > OV_L || cell_voltage[i] < UV_L || temp_flag[i] > OT_L) begin
          cell_fault = 1'b1;
        end
        n_unmasked = n_unmasked + 3'd1;
        if (cell_voltage[i] > v_max) v_max = cell_voltage[i];
        if (cell_voltage[i] < v_min) v_min = cell_voltage[i];
      end
    end
    imb_fault = (n_unmasked >= 3'd2) && ((v_max - v_min) > IMB_L);
    fault_now = cell_fault || imb_fault || (current > OC_L);
  end

  always_comb begin
    flt_run_d = 8'd0;
    clr_run_d = 8'd0;
    if (fault_now) begin
      flt_run_d = (flt_run_q == 8'hFF) ? 8'hFF : flt_run_q + 8'd1;
    end else begin
      clr_run_d = (clr_run_q == 8'hFF) ? 8'hFF : clr_run_q + 8'd1;
    end
  end

  // Decisions use the _d run lengths so the current sample is included.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_NORMAL: begin
        if (fault_now) state_d = ST_WARNING;
      end
      ST_WARNING: begin
        if (!fault_now)                state_d = ST_NORMAL;
        else if (flt_run_d >= PERS_L)  state_d = ST_FAULT;
      end
      ST_FAULT: begin
        if (flt_run_d >= SHDN_L)        state_d = ST_SHUTDOWN;
        else if (clr_run_d >= CLEAR_L)  state_d = ST_NORMAL;
      end
      ST_SHUTDOWN: state_d = ST_SHUTDOWN;
      default:     state_d = ST_NORMAL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_NORMAL;
      flt_run_q <= 8'd0;
      clr_run_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      flt_run_q <= flt_run_d;
      clr_run_q <= clr_run_d;
    end
  end

  assign state           = state_q;
  assign shutdown_signal = (state_q == ST_SHUTDOWN);

endmodule

// File: tb/tb_fault_fsm_moore.sv
// tb/tb_fault_fsm_moore.sv - scoreboard bench for fault_fsm_moore with directed vectors
module tb_fault_fsm_moore;

  localparam logic [1:0] N = 2'b00;
  localparam logic [1:0] W = 2'b01;
  localparam logic [1:0] F = 2'b10;
  localparam logic [1:0] S = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cv [4];
  logic [15:0] current;
  logic [7:0]  temp [4];
  logic [3:0]  mask;
  logic [1:0]  state;
  logic        shutdown_signal;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0] st;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  fault_fsm_moore dut (
    .clk             (clk),
    .reset           (reset),
    .cell_voltage    (cv),
    .current         (current),
    .temp_flag       (temp),
    .mask            (mask),
    .state           (state),
    .shutdown_signal (shutdown_signal)
  );

  always #5 clk = ~clk;

  // Monitor: compares the DUT against each queued expectation on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (state !== e.st) begin
        n_fail++;
        $display("FAIL %s state: got %b expected %b at %0t", e.name, state, e.st, $time);
      end
      n_checks++;
      if (shutdown_signal !== (e.st == S)) begin
        n_fail++;
        $display("FAIL %s shutdown_signal: got %b expected %b at %0t",
                 e.name, shutdown_signal, (e.st == S), $time);
      end
    end
  end

  task automatic nominal();
    for (int i = 0; i < 4; i++) begin
      cv[i]   = 16'd3700;
      temp[i] = 8'd25;
    end
    current = 16'd500;
    mask    = 4'b0000;
  endtask

  task automatic step(input logic [1:0] st, input string name);
    @(posedge clk);
    #1;
    exp_q.push_back('{st, name});
  endtask

  task automatic run(input int n, input logic [1:0] st, input string name);
    repeat (n) step(st, name);
  endtask

  // Asserted between clock edges so the check proves the reset is asynchronous.
  task automatic do_reset(input string name);
    @(posedge clk);
    #3;
    reset = 1'b0;
    exp_q.push_back('{N, name});
    @(negedge clk);
    #2;
    reset = 1'b1;
  endtask

  task automatic to_shutdown(input string name);
    run(3, W, name);
    run(4, F, name);
    run(1, S, name);
  endtask

  initial begin
    reset = 1'b0;
    nominal();
    do_reset("reset_init");

    run(5, N, "t1_nominal");

    cv[1] = 16'd4500;
    step(W, "t2_glitch");
    cv[1] = 16'd3700;
    run(3, N, "t2_recover");

    cv[1] = 16'd4500; temp[2] = 8'd90; current = 16'd1200;
    to_shutdown("t3_persist");
    nominal();
    run(5, S, "t3_sticky");
    do_reset("t3_reset");
    run(2, N, "t3_after_reset");

    cv[3] = 16'd3900;
    to_shutdown("t4_imbalance");
    do_reset("t4_reset");
    nominal();
    cv[3] = 16'd3850;
    run(4, N, "t4_imb_equal");

    nominal();
    mask = 4'b0010; cv[1] = 16'd4500;
    run(3, N, "t5_masked");
    mask = 4'b0000;
    step(W, "t5_unmasked");
    nominal();
    step(N, "t5_recover");

    current = 16'd1200;
    run(3, W, "t6_enter");
    step(F, "t6_fault");
    nominal();
    run(3, F, "t6_clean3");
    cv[0] = 16'd2700;
    step(F, "t6_refault");
    nominal();
    run(3, F, "t6_clean_hold");
    step(N, "t6_cleared");

    for (int i = 0; i < 4; i++) cv[i] = 16'd4200;
    run(2, N, "t6_ov_edge");
    for (int i = 0; i < 4; i++) cv[i] = 16'd2800;
    run(2, N, "t6_uv_edge");
    nominal();
    for (int i = 0; i < 4; i++) temp[i] = 8'd60;
    run(2, N, "t6_ot_edge");
    nominal();
    current = 16'd1000;
    run(2, N, "t6_oc_edge");
    temp[2] = 8'd61;
    step(W, "t6_ot_over");
    nominal();
    step(N, "t6_ot_recover");

    mask = 4'b1111;
    cv[0] = 16'd5000; cv[1] = 16'd100; temp[3] = 8'd200;
    run(2, N, "t7_all_masked");
    current = 16'd1001;
    step(W, "t7_oc_only");
    nominal();
    step(N, "t7_recover");

    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
